// File: rtl/flicky_pkg.sv
// Shared types and sizes for the sprite-collision table and its CPU port.
package flicky_pkg;

   localparam int COLL_AW    = 10;
   localparam int COLL_DEPTH = 1 << COLL_AW;

   typedef enum logic [2:0] {
      S_INIT,
      S_IDLE,
      S_RD,
      S_ACK,
      S_REL
   } state_t;

   // CPU access kind, encoded as {cpu_wr, cpu_sum}
   typedef enum logic [1:0] {
      OP_TBL_RD  = 2'b00,
      OP_SUM_RD  = 2'b01,
      OP_TBL_CLR = 2'b10,
      OP_SUM_CLR = 2'b11
   } cpu_op_t;

   function automatic cpu_op_t decode_op(input logic wr, input logic sum);
      return cpu_op_t'({wr, sum});
   endfunction

endpackage

// File: rtl/flicky_sprcoll_ram_if.sv
// Collision input and CPU req/ack bundle for the sprite-collision table.
interface flicky_sprcoll_ram_if #(
   parameter int AW = flicky_pkg::COLL_AW
);
   logic          sprcoll;
   logic [AW-1:0] sprcoll_ad;
   logic          cpu_req;
   logic          cpu_wr;
   logic          cpu_sum;
   logic [AW-1:0] cpu_ad;
   logic [7:0]    cpu_dout;
   logic          cpu_ack;
   logic          busy;

   // Renderer plus CPU side
   modport master (
      output sprcoll, sprcoll_ad, cpu_req, cpu_wr, cpu_sum, cpu_ad,
      input  cpu_dout, cpu_ack, busy
   );

   // Collision table side
   modport slave (
      input  sprcoll, sprcoll_ad, cpu_req, cpu_wr, cpu_sum, cpu_ad,
      output cpu_dout, cpu_ack, busy
   );
endinterface

// File: rtl/flicky_coll_bitram.sv
// Single-port 2^AW x 1 synchronous RAM with registered read data.
module flicky_coll_bitram
   import flicky_pkg::*;
#(
   parameter int AW = COLL_AW
) (
   input  logic          clk,
   input  logic [AW-1:0] addr,
   input  logic          we,
   input  logic          d,
   output logic          q
);

   logic mem [2**AW];

   // NOTE: the array has no reset so it can map onto block RAM; the owner clears it by sweeping.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= d;
      end else begin
         q <= mem[addr];
      end
   end

endmodule

// File: rtl/flicky_sprcoll_ram.sv
// Sprite-collision table: collision pulses set bits and a summary flag; the CPU reads/clears via req/ack.
module flicky_sprcoll_ram
   import flicky_pkg::*;
#(
   parameter int AW = COLL_AW
) (
   input  logic                VCLKx4,
   input  logic                RESET,
   flicky_sprcoll_ram_if.slave bus
);

   localparam logic [AW:0] LAST = (AW+1)'((2**AW) - 1);

   state_t        state, state_n;
   logic [AW:0]   cnt;
   logic          summary;
   logic [7:0]    dout_q;
   logic          ack_q;

   logic [AW-1:0] ram_addr;
   logic          ram_we;
   logic          ram_d;
   logic          ram_q;
   logic          sum_set;
   logic          sum_clr;
   logic          dout_ld;
   logic          dout_bit;

   flicky_coll_bitram #(.AW(AW)) u_ram (
      .clk  (VCLKx4),
      .addr (ram_addr),
      .we   (ram_we),
      .d    (ram_d),
      .q    (ram_q)
   );

   // NOTE: every output of this block gets a default first, so no path leaves one unassigned (no latches).
   always_comb begin
      state_n  = state;
      ram_addr = bus.cpu_ad;
      ram_we   = 1'b0;
      ram_d    = 1'b0;
      sum_set  = 1'b0;
      sum_clr  = 1'b0;
      dout_ld  = 1'b0;
      dout_bit = 1'b0;

      // Collisions own the RAM port in every state outside the sweep
      if (state != S_INIT && bus.sprcoll) begin
         ram_we   = 1'b1;
         ram_addr = bus.sprcoll_ad;
         ram_d    = 1'b1;
         sum_set  = 1'b1;
      end

      unique case (state)
         S_INIT: begin
            ram_we   = 1'b1;
            ram_addr = cnt[AW-1:0];
            ram_d    = 1'b0;
            if (cnt == LAST) state_n = S_IDLE;
         end
         S_IDLE: begin
            if (!bus.sprcoll && bus.cpu_req) begin
               unique case (decode_op(bus.cpu_wr, bus.cpu_sum))
                  OP_TBL_RD: state_n = S_RD;
                  OP_TBL_CLR: begin
                     ram_we  = 1'b1;
                     ram_d   = 1'b0;
                     state_n = S_ACK;
                  end
                  OP_SUM_RD: begin
                     dout_ld  = 1'b1;
                     dout_bit = summary;
                     state_n  = S_ACK;
                  end
                  OP_SUM_CLR: begin
                     sum_clr = 1'b1;
                     state_n = S_ACK;
                  end
               endcase
            end
         end
         S_RD: begin
            dout_ld  = 1'b1;
            dout_bit = ram_q;
            state_n  = S_ACK;
         end
         S_ACK: state_n = S_REL;
         S_REL: if (!bus.cpu_req) state_n = S_IDLE;
         default: state_n = S_INIT;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge VCLKx4) begin
      if (RESET) begin
         state   <= S_INIT;
         cnt     <= '0;
         summary <= 1'b0;
         dout_q  <= '0;
         ack_q   <= 1'b0;
      end else begin
         state <= state_n;
         cnt   <= (state == S_INIT) ? cnt + 1'b1 : '0;
         // A set in the same cycle as a clear leaves the flag raised
         if (sum_set) begin
            summary <= 1'b1;
         end else if (sum_clr) begin
            summary <= 1'b0;
         end
         if (dout_ld) dout_q <= {7'b0, dout_bit};
         ack_q <= (state == S_ACK);
      end
   end

   assign bus.cpu_dout = dout_q;
   assign bus.cpu_ack  = ack_q;
   assign bus.busy     = (state == S_INIT);

endmodule

// File: tb/tb_flicky_sprcoll_ram.sv
// Scoreboard bench for flicky_sprcoll_ram: directed cases then randomized CPU/collision traffic.
module tb_flicky_sprcoll_ram;
   import flicky_pkg::*;

   logic VCLKx4 = 1'b0;
   logic RESET  = 1'b1;

   flicky_sprcoll_ram_if #(.AW(COLL_AW)) bus ();

   flicky_sprcoll_ram #(.AW(COLL_AW)) dut (
      .VCLKx4 (VCLKx4),
      .RESET  (RESET),
      .bus    (bus.slave)
   );

   always #5 VCLKx4 = ~VCLKx4;

   typedef struct {
      bit         is_read;
      logic [7:0] data;
      string      name;
   } exp_t;

   int   n_checks = 0;
   int   n_errors = 0;
   exp_t exp_q[$];
   bit   model_tab[COLL_DEPTH];
   bit   model_sum;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: every ack retires one pending transaction; reads compare their data
   always @(negedge VCLKx4) begin
      if (bus.cpu_ack === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_ack: got ack with 0 pending, expected none");
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            if (e.is_read) check({e.name, "_data"}, {24'b0, bus.cpu_dout}, {24'b0, e.data});
         end
      end
   end

   function automatic void model_coll(input logic [9:0] a);
      model_tab[a] = 1'b1;
      model_sum    = 1'b1;
   endfunction

   task automatic step();
      @(posedge VCLKx4);
      #1;
   endtask

   // Reset, check reset state, then count busy cycles; optionally fire a collision mid-sweep
   task automatic reset_sweep(input int coll_cycle, input logic [9:0] coll_ad);
      int count;
      RESET = 1'b1;
      bus.cpu_req = 1'b0;
      bus.sprcoll = 1'b0;
      step();
      check("rst_dout", {24'b0, bus.cpu_dout}, 32'h0);
      check("rst_ack", {31'b0, bus.cpu_ack}, 32'h0);
      check("rst_busy", {31'b0, bus.busy}, 32'h1);
      RESET = 1'b0;
      count = 0;
      while (bus.busy === 1'b1 && count < 2000) begin
         bus.sprcoll    = (count == coll_cycle);
         bus.sprcoll_ad = coll_ad;
         step();
         count++;
      end
      bus.sprcoll = 1'b0;
      check("busy_cycles", count, 1024);
      foreach (model_tab[i]) model_tab[i] = 1'b0;
      model_sum = 1'b0;
   endtask

   task automatic pulse(input logic [9:0] a);
      bus.sprcoll    = 1'b1;
      bus.sprcoll_ad = a;
      model_coll(a);
      step();
      bus.sprcoll = 1'b0;
      step();
   endtask

   // mode 0: no collision; 1: collision in the request cycle; 2: collision one cycle later
   task automatic do_op(input cpu_op_t op, input logic [9:0] ad, input int mode,
                        input logic [9:0] cad, input string name);
      exp_t       e;
      logic [1:0] code;
      int         n, want;
      bit         got;
      code           = op;
      bus.cpu_req    = 1'b1;
      bus.cpu_wr     = code[1];
      bus.cpu_sum    = code[0];
      bus.cpu_ad     = ad;
      bus.sprcoll    = (mode == 1);
      bus.sprcoll_ad = cad;
      if (mode == 1) model_coll(cad);
      e.is_read = (op == OP_TBL_RD) || (op == OP_SUM_RD);
      e.name    = name;
      e.data    = 8'h00;
      case (op)
         OP_TBL_RD:  e.data = {7'b0, model_tab[ad]};
         OP_SUM_RD:  e.data = {7'b0, model_sum};
         OP_TBL_CLR: model_tab[ad] = 1'b0;
         OP_SUM_CLR: model_sum = 1'b0;
      endcase
      exp_q.push_back(e);
      if (mode == 2) model_coll(cad);
      want = ((op == OP_TBL_RD) ? 3 : 2) + ((mode == 1) ? 1 : 0);
      n   = 0;
      got = 1'b0;
      while (!got && n < 16) begin
         step();
         n++;
         bus.sprcoll = (n == 1) && (mode == 2);
         if (bus.cpu_ack === 1'b1) got = 1'b1;
      end
      bus.sprcoll = 1'b0;
      check({name, "_latency"}, n, want);
      bus.cpu_req = 1'b0;
      step();
      check({name, "_ack_width"}, {31'b0, bus.cpu_ack}, 32'h0);
   endtask

   initial begin
      bus.sprcoll    = 1'b0;
      bus.sprcoll_ad = '0;
      bus.cpu_req    = 1'b0;
      bus.cpu_wr     = 1'b0;
      bus.cpu_sum    = 1'b0;
      bus.cpu_ad     = '0;
      model_sum      = 1'b0;
      repeat (3) @(posedge VCLKx4);
      #1;

      // Sweep with a collision at cycle 500 that must be discarded
      reset_sweep(500, 10'h155);
      do_op(OP_TBL_RD, 10'h155, 0, 10'h0, "sweep_coll_rd");
      do_op(OP_TBL_RD, 10'h000, 0, 10'h0, "init_rd_first");
      do_op(OP_TBL_RD, 10'h3FF, 0, 10'h0, "init_rd_last");
      do_op(OP_SUM_RD, 10'h000, 0, 10'h0, "init_sum");

      pulse(10'h2A5);
      do_op(OP_TBL_RD, 10'h2A5, 0, 10'h0, "coll_rd_hit");
      do_op(OP_TBL_RD, 10'h2A4, 0, 10'h0, "coll_rd_miss");
      do_op(OP_SUM_RD, 10'h000, 0, 10'h0, "coll_sum");

      do_op(OP_TBL_RD, 10'h2A5, 1, 10'h013, "coll_first_rd");
      do_op(OP_TBL_RD, 10'h013, 0, 10'h0, "coll_first_013");

      do_op(OP_TBL_CLR, 10'h2A5, 0, 10'h0, "tbl_clr");
      do_op(OP_TBL_RD, 10'h2A5, 0, 10'h0, "tbl_clr_rd");
      do_op(OP_SUM_CLR, 10'h000, 0, 10'h0, "sum_clr");
      do_op(OP_SUM_RD, 10'h000, 0, 10'h0, "sum_clr_rd");

      do_op(OP_SUM_CLR, 10'h000, 2, 10'h0AA, "sum_clr_vs_coll");
      do_op(OP_SUM_RD, 10'h000, 0, 10'h0, "sum_set_wins");

      do_op(OP_TBL_CLR, 10'h0AB, 1, 10'h0AB, "clr_after_coll");
      do_op(OP_TBL_RD, 10'h0AB, 0, 10'h0, "clr_after_coll_rd");

      for (int i = 0; i < 60; i++) begin
         cpu_op_t    op;
         logic [9:0] ad, cad;
         op  = cpu_op_t'(2'($urandom_range(0, 3)));
         ad  = ($urandom_range(0, 1) == 1) ? 10'($urandom) : 10'h2A0 + 10'($urandom_range(0, 7));
         cad = ($urandom_range(0, 1) == 1) ? 10'($urandom) : 10'h2A0 + 10'($urandom_range(0, 7));
         if ($urandom_range(0, 2) == 0) pulse(10'h2A0 + 10'($urandom_range(0, 7)));
         do_op(op, ad, $urandom_range(0, 2), cad, "rand");
      end

      // Reset while a table read is between issue and data: the transaction must vanish
      pulse(10'h013);
      do_op(OP_SUM_RD, 10'h000, 0, 10'h0, "pre_rst_sum");
      bus.cpu_req = 1'b1;
      bus.cpu_wr  = 1'b0;
      bus.cpu_sum = 1'b0;
      bus.cpu_ad  = 10'h013;
      step();
      RESET = 1'b1;
      step();
      check("midrd_dout", {24'b0, bus.cpu_dout}, 32'h0);
      check("midrd_ack", {31'b0, bus.cpu_ack}, 32'h0);
      check("midrd_busy", {31'b0, bus.busy}, 32'h1);
      reset_sweep(-1, 10'h0);
      do_op(OP_TBL_RD, 10'h013, 0, 10'h0, "post_rst_rd");
      do_op(OP_SUM_RD, 10'h000, 0, 10'h0, "post_rst_sum");

      repeat (4) step();
      check("scoreboard_drained", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
